int_issue_queue: RTL

- Receiving end of the integer dispatch interface: a reservation-station FIFO for the integer ALU.
- Accepts one dispatched instruction per cycle and holds it with operand data or pending tags.
- Snoops the CDB to wake up pending operands, then issues the oldest fully-ready entry to the integer execution unit.
- Drives issueque_full back to dispatch.

---
 rtl/int_issue_queue_pkg.sv | 19 +
 rtl/int_issue_queue_iq_entry.sv | 65 ++++++
 rtl/int_issue_queue.sv | 121 ++++++++++++
 3 files changed

// File: rtl/int_issue_queue_pkg.sv
// int_issue_queue_pkg: shared width defaults and ALU opcode list for the integer issue queue.
package int_issue_queue_pkg;
    localparam int IQ_DATA_WIDTH   = 32;
    localparam int IQ_TAG_WIDTH    = 6;
    localparam int IQ_OPCODE_WIDTH = 5;

    typedef enum logic [IQ_OPCODE_WIDTH-1:0] {
        ALU_ADD  = 5'h00,
        ALU_SUB  = 5'h01,
        ALU_AND  = 5'h02,
        ALU_OR   = 5'h03,
        ALU_XOR  = 5'h04,
        ALU_SLL  = 5'h05,
        ALU_SRL  = 5'h06,
        ALU_SRA  = 5'h07,
        ALU_SLT  = 5'h08,
        ALU_SLTU = 5'h09
    } alu_op_e;
endpackage

// File: rtl/int_issue_queue_iq_entry.sv
// iq_entry: one issue-queue slot; registers the content chosen by the top and applies CDB wakeup to it.
module iq_entry import int_issue_queue_pkg::*; #(
    parameter int DATA_WIDTH   = IQ_DATA_WIDTH,
    parameter int TAG_WIDTH    = IQ_TAG_WIDTH,
    parameter int OPCODE_WIDTH = IQ_OPCODE_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cdb_valid,
    input  logic [TAG_WIDTH-1:0]    cdb_tag,
    input  logic [DATA_WIDTH-1:0]   cdb_data,
    input  logic                    d_busy,
    input  logic [OPCODE_WIDTH-1:0] d_opcode,
    input  logic [TAG_WIDTH-1:0]    d_rd_tag,
    input  logic [DATA_WIDTH-1:0]   d_imm,
    input  logic                    d_pend1,
    input  logic [TAG_WIDTH-1:0]    d_tag1,
    input  logic [DATA_WIDTH-1:0]   d_data1,
    input  logic                    d_pend2,
    input  logic [TAG_WIDTH-1:0]    d_tag2,
    input  logic [DATA_WIDTH-1:0]   d_data2,
    output logic                    q_busy,
    output logic [OPCODE_WIDTH-1:0] q_opcode,
    output logic [TAG_WIDTH-1:0]    q_rd_tag,
    output logic [DATA_WIDTH-1:0]   q_imm,
    output logic                    q_pend1,
    output logic [TAG_WIDTH-1:0]    q_tag1,
    output logic [DATA_WIDTH-1:0]   q_data1,
    output logic                    q_pend2,
    output logic [TAG_WIDTH-1:0]    q_tag2,
    output logic [DATA_WIDTH-1:0]   q_data2,
    output logic                    ready
);
    // Wakeup acts on the incoming content, so shifted and freshly dispatched entries are covered too.
    logic hit1, hit2;
    assign hit1  = d_pend1 & cdb_valid & (d_tag1 == cdb_tag);
    assign hit2  = d_pend2 & cdb_valid & (d_tag2 == cdb_tag);
    assign ready = q_busy & ~q_pend1 & ~q_pend2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_busy   <= 1'b0;
            q_opcode <= '0;
            q_rd_tag <= '0;
            q_imm    <= '0;
            q_pend1  <= 1'b0;
            q_tag1   <= '0;
            q_data1  <= '0;
            q_pend2  <= 1'b0;
            q_tag2   <= '0;
            q_data2  <= '0;
        end else begin
            q_busy   <= d_busy;
            q_opcode <= d_opcode;
            q_rd_tag <= d_rd_tag;
            q_imm    <= d_imm;
            q_pend1  <= d_pend1 & ~hit1;
            q_tag1   <= d_tag1;
            q_data1  <= hit1 ? cdb_data : d_data1;
            q_pend2  <= d_pend2 & ~hit2;
            q_tag2   <= d_tag2;
            q_data2  <= hit2 ? cdb_data : d_data2;
        end
    end
endmodule

// File: rtl/int_issue_queue.sv
// int_issue_queue: collapsing reservation-station FIFO for the integer ALU; issues the oldest ready entry.
module int_issue_queue import int_issue_queue_pkg::*; #(
    parameter int DEPTH        = 4,
    parameter int DATA_WIDTH   = IQ_DATA_WIDTH,
    parameter int TAG_WIDTH    = IQ_TAG_WIDTH,
    parameter int OPCODE_WIDTH = IQ_OPCODE_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    dispatch_en,
    input  logic [OPCODE_WIDTH-1:0] dispatch_opcode,
    input  logic [TAG_WIDTH-1:0]    dispatch_rd_tag,
    input  logic [DATA_WIDTH-1:0]   dispatch_rs1_data,
    input  logic [TAG_WIDTH-1:0]    dispatch_rs1_tag,
    input  logic                    dispatch_rs1_valid,
    input  logic [DATA_WIDTH-1:0]   dispatch_rs2_data,
    input  logic [TAG_WIDTH-1:0]    dispatch_rs2_tag,
    input  logic                    dispatch_rs2_valid,
    input  logic [DATA_WIDTH-1:0]   dispatch_imm,
    input  logic [TAG_WIDTH-1:0]    CDB_tag,
    input  logic                    CDB_valid,
    input  logic [DATA_WIDTH-1:0]   CDB_data,
    output logic                    issueque_full,
    input  logic                    issue_ready,
    output logic                    issue_valid,
    output logic [OPCODE_WIDTH-1:0] issue_opcode,
    output logic [DATA_WIDTH-1:0]   issue_rs1_data,
    output logic [DATA_WIDTH-1:0]   issue_rs2_data,
    output logic [DATA_WIDTH-1:0]   issue_imm,
    output logic [TAG_WIDTH-1:0]    issue_rd_tag
);
    localparam int CW = $clog2(DEPTH + 1);

    // Index DEPTH is a permanently empty phantom slot feeding the top slot during a collapse.
    logic                    q_busy   [DEPTH+1];
    logic [OPCODE_WIDTH-1:0] q_opcode [DEPTH+1];
    logic [TAG_WIDTH-1:0]    q_rd_tag [DEPTH+1];
    logic [DATA_WIDTH-1:0]   q_imm    [DEPTH+1];
    logic                    q_pend1  [DEPTH+1];
    logic [TAG_WIDTH-1:0]    q_tag1   [DEPTH+1];
    logic [DATA_WIDTH-1:0]   q_data1  [DEPTH+1];
    logic                    q_pend2  [DEPTH+1];
    logic [TAG_WIDTH-1:0]    q_tag2   [DEPTH+1];
    logic [DATA_WIDTH-1:0]   q_data2  [DEPTH+1];
    logic [DEPTH-1:0]        rdy;
    logic [CW-1:0]           count, cnt_c, sel;
    logic                    fire, do_disp;

    assign q_busy[DEPTH]   = 1'b0;
    assign q_opcode[DEPTH] = '0;
    assign q_rd_tag[DEPTH] = '0;
    assign q_imm[DEPTH]    = '0;
    assign q_pend1[DEPTH]  = 1'b0;
    assign q_tag1[DEPTH]   = '0;
    assign q_data1[DEPTH]  = '0;
    assign q_pend2[DEPTH]  = 1'b0;
    assign q_tag2[DEPTH]   = '0;
    assign q_data2[DEPTH]  = '0;

    assign issueque_full = (count == CW'(DEPTH));
    assign issue_valid   = |rdy;
    assign fire          = issue_valid & issue_ready;
    assign do_disp       = dispatch_en & ~issueque_full;
    assign cnt_c         = count - CW'(fire);

    always_comb begin
        sel = '0;
        for (int k = DEPTH - 1; k >= 0; k--)
            if (rdy[k]) sel = CW'(k);
    end

    assign issue_opcode   = issue_valid ? q_opcode[sel] : '0;
    assign issue_rs1_data = issue_valid ? q_data1[sel]  : '0;
    assign issue_rs2_data = issue_valid ? q_data2[sel]  : '0;
    assign issue_imm      = issue_valid ? q_imm[sel]    : '0;
    assign issue_rd_tag   = issue_valid ? q_rd_tag[sel] : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) count <= '0;
        else count <= flush ? '0 : cnt_c + CW'(do_disp);
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        logic ins, sh;
        assign ins = do_disp && (cnt_c == CW'(i));
        assign sh  = fire && (sel <= CW'(i));
        iq_entry #(
            .DATA_WIDTH  (DATA_WIDTH),
            .TAG_WIDTH   (TAG_WIDTH),
            .OPCODE_WIDTH(OPCODE_WIDTH)
        ) u_entry (
            .clk      (clk),
            .reset    (reset),
            .cdb_valid(CDB_valid),
            .cdb_tag  (CDB_tag),
            .cdb_data (CDB_data),
            .d_busy   (~flush & (ins | (sh ? q_busy[i+1] : q_busy[i]))),
            .d_opcode (ins ? dispatch_opcode    : sh ? q_opcode[i+1] : q_opcode[i]),
            .d_rd_tag (ins ? dispatch_rd_tag    : sh ? q_rd_tag[i+1] : q_rd_tag[i]),
            .d_imm    (ins ? dispatch_imm       : sh ? q_imm[i+1]    : q_imm[i]),
            .d_pend1  (ins ? dispatch_rs1_valid : sh ? q_pend1[i+1]  : q_pend1[i]),
            .d_tag1   (ins ? dispatch_rs1_tag   : sh ? q_tag1[i+1]   : q_tag1[i]),
            .d_data1  (ins ? dispatch_rs1_data  : sh ? q_data1[i+1]  : q_data1[i]),
            .d_pend2  (ins ? dispatch_rs2_valid : sh ? q_pend2[i+1]  : q_pend2[i]),
            .d_tag2   (ins ? dispatch_rs2_tag   : sh ? q_tag2[i+1]   : q_tag2[i]),
            .d_data2  (ins ? dispatch_rs2_data  : sh ? q_data2[i+1]  : q_data2[i]),
            .q_busy   (q_busy[i]),
            .q_opcode (q_opcode[i]),
            .q_rd_tag (q_rd_tag[i]),
            .q_imm    (q_imm[i]),
            .q_pend1  (q_pend1[i]),
            .q_tag1   (q_tag1[i]),
            .q_data1  (q_data1[i]),
            .q_pend2  (q_pend2[i]),
            .q_tag2   (q_tag2[i]),
            .q_data2  (q_data2[i]),
            .ready    (rdy[i])
        );
    end
endmodule
